// File: rtl/move_debouncer.sv
// Button conditioner for the 2048 game FSM: synchronizes and debounces four
// active-low buttons and turns each accepted press into one active-low move pulse.
module move_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn_right,
  input  logic i_btn_left,
  input  logic i_btn_up,
  input  logic i_btn_down,
  output logic o_mov_right,
  output logic o_mov_left,
  output logic o_mov_up,
  output logic o_mov_down,
  output logic o_busy
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LP_TERM = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FIRE,
    ST_WAIT_RELEASE
  } state_t;

  logic [3:0] w_btn;
  logic [3:0] w_deb;
  logic [3:0] w_press;
  logic [3:0] w_win;
  logic [3:0] w_fire;
  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_mov;
  logic       r_busy;

  // Bit order throughout: 0 = right, 1 = left, 2 = up, 3 = down.
  assign w_btn = {i_btn_down, i_btn_up, i_btn_left, i_btn_right};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
      logic          r_s1;
      logic          r_s2;
      logic          r_deb;
      logic [CW-1:0] r_cnt;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_s1  <= 1'b1;
          r_s2  <= 1'b1;
          r_deb <= 1'b1;
          r_cnt <= '0;
        end else begin
          r_s1 <= w_btn[gi];
          r_s2 <= r_s1;
          if (r_s2 == r_deb) begin
            r_cnt <= '0;
          end else if (r_cnt == LP_TERM) begin
            r_deb <= r_s2;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end

      assign w_deb[gi]   = r_deb;
      // High in the cycle whose edge will flip the debounced level to pressed.
      assign w_press[gi] = r_deb & ~r_s2 & (r_cnt == LP_TERM);
    end
  endgenerate

  // Isolate the lowest set bit, giving right > left > up > down.
  assign w_win = w_press & (~w_press + 4'd1);

  always_comb begin
    w_state_next = r_state;
    w_fire       = 4'b0000;
    case (r_state)
      ST_IDLE: begin
        if (|w_press) begin
          w_fire       = w_win;
          w_state_next = ST_FIRE;
        end
      end
      ST_FIRE:         w_state_next = ST_WAIT_RELEASE;
      ST_WAIT_RELEASE: if (&w_deb) w_state_next = ST_IDLE;
      default:         w_state_next = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change on the same edge as the state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_mov   <= 4'b1111;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_mov   <= ~w_fire;
      r_busy  <= (w_state_next != ST_IDLE);
    end
  end

  assign o_mov_right = r_mov[0];
  assign o_mov_left  = r_mov[1];
  assign o_mov_up    = r_mov[2];
  assign o_mov_down  = r_mov[3];
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_move_debouncer.sv
// Bench for move_debouncer: directed scenarios plus random button activity,
// checked every cycle against a sample-window model of debounce and arbitration.
module tb_move_debouncer;
  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] btn = 4'hF;
  logic       mov_r, mov_l, mov_u, mov_d, busy;
  logic [3:0] mov;

  assign mov = {mov_d, mov_u, mov_l, mov_r};

  move_debouncer #(.DEBOUNCE_CYCLES(DC)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_btn_right(btn[0]),
    .i_btn_left (btn[1]),
    .i_btn_up   (btn[2]),
    .i_btn_down (btn[3]),
    .o_mov_right(mov_r),
    .o_mov_left (mov_l),
    .o_mov_up   (mov_u),
    .o_mov_down (mov_d),
    .o_busy     (busy)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: h[b][j] is the raw level sampled j+1 edges ago.
  logic       h [0:3][0:DC];
  logic       m_deb [0:3];
  int         m_since [0:3];
  int         m_state;
  int         m_win;
  logic [3:0] exp_mov;
  logic       exp_busy;

  int   pulse_cnt [0:3];
  int   last_pulse [0:3];
  int   busy_fall = -1;
  logic busy_prev = 1'b0;

  function automatic void model_reset();
    for (int b = 0; b < 4; b++) begin
      for (int j = 0; j <= DC; j++) h[b][j] = 1'b1;
      m_deb[b]   = 1'b1;
      m_since[b] = DC;
    end
    m_state  = 0;
    m_win    = 0;
    exp_mov  = 4'hF;
    exp_busy = 1'b0;
  endfunction

  // A debounced level flips once the DC samples feeding it all disagree with it
  // and at least DC edges have passed since its previous flip.
  function automatic void model_edge();
    logic [3:0] flip;
    logic [3:0] evt;
    logic       diff;
    logic       all_rel;
    all_rel = 1'b1;
    for (int b = 0; b < 4; b++) begin
      m_since[b]++;
      diff = 1'b1;
      for (int j = 1; j <= DC; j++) if (h[b][j] == m_deb[b]) diff = 1'b0;
      flip[b] = diff && (m_since[b] >= DC);
      evt[b]  = flip[b] && m_deb[b];
      if (!m_deb[b]) all_rel = 1'b0;
    end
    if (m_state == 0) begin
      if (evt != 4'b0) begin
        m_win = 3;
        for (int b = 3; b >= 0; b--) if (evt[b]) m_win = b;
        m_state = 1;
      end
    end else if (m_state == 1) begin
      m_state = 2;
    end else if (all_rel) begin
      m_state = 0;
    end
    for (int b = 0; b < 4; b++) begin
      if (flip[b]) begin
        m_deb[b]   = ~m_deb[b];
        m_since[b] = 0;
      end
      for (int j = DC; j >= 1; j--) h[b][j] = h[b][j-1];
      h[b][0] = btn[b];
    end
    exp_busy = (m_state != 0);
    exp_mov  = 4'hF;
    if (m_state == 1) exp_mov[m_win] = 1'b0;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (clk) cyc++;
      if (!rst_n) model_reset();
      else model_edge();
    end
  end

  initial begin
    for (int b = 0; b < 4; b++) begin
      pulse_cnt[b]  = 0;
      last_pulse[b] = -1;
    end
    forever begin
      @(negedge clk);
      checks++;
      if (mov !== exp_mov || busy !== exp_busy) begin
        errors++;
        $display("FAIL cycle_compare cyc=%0d: got mov=%b busy=%b, expected mov=%b busy=%b",
                 cyc, mov, busy, exp_mov, exp_busy);
      end
      for (int b = 0; b < 4; b++) begin
        if (mov[b] === 1'b0) begin
          pulse_cnt[b]++;
          last_pulse[b] = cyc;
          $display("pulse: move %0d at cycle %0d", b, cyc);
        end
      end
      if (busy_prev === 1'b1 && busy === 1'b0) busy_fall = cyc;
      busy_prev = busy;
    end
  end

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  int t0, tr, t2;
  int base [0:3];
  int rnd_total;

  task automatic snap();
    for (int b = 0; b < 4; b++) base[b] = pulse_cnt[b];
  endtask

  initial begin
    #1 rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;

    // Reset values
    tick(50);
    chk("reset_no_pulses", pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3], 0);
    chk("reset_busy", int'(busy), 0);

    // Clean press on right
    snap();
    t0 = cyc;
    btn[0] = 1'b0;
    tick(20);
    chk("clean_right_count", pulse_cnt[0] - base[0], 1);
    chk("clean_right_time", last_pulse[0], t0 + 6);
    chk("clean_busy_held", int'(busy), 1);
    btn[0] = 1'b1;
    tr = cyc;
    tick(15);
    chk("clean_busy_fall", busy_fall, tr + 7);
    chk("clean_others", pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3] - base[1] - base[2] - base[3], 0);

    // Bouncing down button
    snap();
    repeat (5) begin
      btn[3] = 1'b0;
      tick(2);
      btn[3] = 1'b1;
      tick(1);
    end
    t0 = cyc;
    btn[3] = 1'b0;
    tick(10);
    chk("bounce_down_count", pulse_cnt[3] - base[3], 1);
    chk("bounce_down_time", last_pulse[3], t0 + 6);
    btn[3] = 1'b1;
    tick(15);

    // Simultaneous left and up
    snap();
    btn[1] = 1'b0;
    btn[2] = 1'b0;
    tick(15);
    chk("simul_left_count", pulse_cnt[1] - base[1], 1);
    chk("simul_up_count", pulse_cnt[2] - base[2], 0);
    btn[1] = 1'b1;
    tick(15);
    chk("simul_busy_loser_held", int'(busy), 1);
    btn[2] = 1'b1;
    tr = cyc;
    tick(15);
    chk("simul_busy_fall", busy_fall, tr + 7);
    chk("simul_up_after", pulse_cnt[2] - base[2], 0);

    // Hold lockout
    snap();
    btn[2] = 1'b0;
    tick(95);
    btn[0] = 1'b0;
    tick(10);
    btn[0] = 1'b1;
    tick(95);
    btn[2] = 1'b1;
    tick(15);
    chk("lockout_up_count", pulse_cnt[2] - base[2], 1);
    chk("lockout_right_count", pulse_cnt[0] - base[0], 0);

    // Reset during FIRE with right held
    snap();
    t0 = cyc;
    btn[0] = 1'b0;
    tick(6);
    chk("midrst_fire_low", int'(mov_r), 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_truncated_mov", int'(mov_r), 1);
    chk("midrst_busy_cleared", int'(busy), 0);
    tick(3);
    rst_n = 1'b1;
    t2 = cyc;
    tick(10);
    chk("midrst_right_count", pulse_cnt[0] - base[0], 2);
    chk("midrst_second_time", last_pulse[0], t2 + 6);
    btn[0] = 1'b1;
    tick(15);

    // Random activity
    snap();
    repeat (3000) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 9) == 0) btn[b] = ~btn[b];
      if ($urandom_range(0, 799) == 0) begin
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
      end
      if ($urandom_range(0, 149) == 0) begin
        btn = 4'hF;
        tick(12);
      end
      tick(1);
    end
    btn = 4'hF;
    tick(20);
    rnd_total = 0;
    for (int b = 0; b < 4; b++) rnd_total += pulse_cnt[b] - base[b];
    chk("random_any_pulse", int'(rnd_total > 0), 1);
    chk("final_idle", int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
